// File: rtl/data_memory.sv
// Multi-cycle 256x8 data memory that stalls the core through BUSYWAIT for ACCESS_LATENCY edges per access.
// Define DMEM_STATS_EN to add saturating LOAD_COUNT/STORE_COUNT outputs.
module data_memory #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int ACCESS_LATENCY = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  BUSYWAIT
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]           LOAD_COUNT,
  output logic [15:0]           STORE_COUNT
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] COUNT_INIT = 4'(ACCESS_LATENCY - 1);

  state_t                state;
  logic [3:0]            count;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic                  lat_write;
  logic                  complete;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign complete = (state == ACCESS) && (count == 4'd0);
  assign BUSYWAIT = ((state == IDLE) && (READ || WRITE)) || (state == ACCESS);

  // The array has no reset; a reset on the completion edge suppresses the store.
  always_ff @(posedge CLK) begin
    if (RESET && complete && lat_write) begin
      mem[lat_addr] <= lat_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      count     <= 4'd0;
      READDATA  <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (READ || WRITE) begin
            lat_addr  <= ADDRESS;
            lat_data  <= WRITEDATA;
            lat_write <= WRITE;
            count     <= COUNT_INIT;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            if (!lat_write) begin
              READDATA <= mem[lat_addr];
            end
            state <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      LOAD_COUNT  <= 16'd0;
      STORE_COUNT <= 16'd0;
    end else if (complete) begin
      if (lat_write && (STORE_COUNT != 16'hFFFF)) begin
        STORE_COUNT <= STORE_COUNT + 16'd1;
      end
      if (!lat_write && (LOAD_COUNT != 16'hFFFF)) begin
        LOAD_COUNT <= LOAD_COUNT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: one instance at latency 5, one at latency 1.
// Stats outputs are checked when DMEM_STATS_EN is defined.
module tb_data_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_rd;
  logic       req_wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       sel1;
  logic [7:0] rdata0, rdata1;
  logic       bw0, bw1;
`ifdef DMEM_STATS_EN
  logic [15:0] ld0, st0, ld1, st1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = 0;

  logic [7:0] mdl [2][256];
  logic [7:0] last_rd [2];
  int         ld_m [2];
  int         st_m [2];
  logic [7:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory #(.ACCESS_LATENCY(5)) u_dut0 (
    .CLK(clk), .RESET(rst_n), .READ(req_rd & ~sel1), .WRITE(req_wr & ~sel1),
    .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata0), .BUSYWAIT(bw0)
`ifdef DMEM_STATS_EN
    , .LOAD_COUNT(ld0), .STORE_COUNT(st0)
`endif
  );

  data_memory #(.ACCESS_LATENCY(1)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .READ(req_rd & sel1), .WRITE(req_wr & sel1),
    .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata1), .BUSYWAIT(bw1)
`ifdef DMEM_STATS_EN
    , .LOAD_COUNT(ld1), .STORE_COUNT(st1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic busy();
    return sel1 ? bw1 : bw0;
  endfunction

  function automatic logic [7:0] rdata();
    return sel1 ? rdata1 : rdata0;
  endfunction

  // mode 0: drop request at DONE; 1: disturb inputs and drop request after T0; 2: hold request through DONE
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int mode);
    int edges;
    int lat;
    logic b;
    lat = sel1 ? 1 : 5;
    @(negedge clk);
    req_rd = rd; req_wr = wr; addr = a; wdata = d;
    #1;
    check("busy_on_request", busy(), 1'b1);
    if (rd && !wr) sb.push_back(mdl[sel1][a]);
    if (wr) mdl[sel1][a] = d;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      b = busy();
      if (mode == 1 && edges == 1) begin
        addr = a + 8'd1; wdata = ~d; req_rd = 1'b0; req_wr = 1'b0;
      end
    end while (b && edges < 40);
    check("latency", edges - 1, lat);
    done_cyc = cyc;
    if (mode != 2) begin
      req_rd = 1'b0; req_wr = 1'b0;
    end
    if (rd && !wr) last_rd[sel1] = sb.pop_front();
    check("readdata", rdata(), last_rd[sel1]);
    if (wr) st_m[sel1]++;
    else if (rd) ld_m[sel1]++;
`ifdef DMEM_STATS_EN
    check("load_count", sel1 ? ld1 : ld0, ld_m[sel1]);
    check("store_count", sel1 ? st1 : st0, st_m[sel1]);
`endif
  endtask

  task automatic clear_model_regs();
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = 8'h00; ld_m[i] = 0; st_m[i] = 0;
    end
  endtask

  initial begin
    int prev;
    rst_n = 1'b0; req_rd = 1'b0; req_wr = 1'b0; addr = 8'h00; wdata = 8'h00; sel1 = 1'b0;
    clear_model_regs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_readdata0", rdata0, 8'h00);
    check("reset_readdata1", rdata1, 8'h00);
    check("reset_busy0", bw0, 1'b0);
    check("reset_busy1", bw1, 1'b0);
    rst_n = 1'b1;

    // store then load
    access(1'b0, 1'b1, 8'h10, 8'h5A, 0);
    @(negedge clk);
    check("done_to_idle_busy", bw0, 1'b0);
    access(1'b1, 1'b0, 8'h10, 8'h00, 0);

    // reset in the middle of a store
    access(1'b0, 1'b1, 8'h20, 8'h11, 0);
    @(negedge clk);
    req_wr = 1'b1; addr = 8'h20; wdata = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; req_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_readdata", rdata0, 8'h00);
    check("abort_busy", bw0, 1'b0);
    rst_n = 1'b1;
    clear_model_regs();
    access(1'b1, 1'b0, 8'h20, 8'h00, 0);

    // read/write collision: store wins, READDATA kept
    access(1'b1, 1'b1, 8'h03, 8'hC3, 0);
    access(1'b1, 1'b0, 8'h03, 8'h00, 0);

    // inputs disturbed and request dropped during ACCESS
    access(1'b0, 1'b1, 8'h40, 8'h77, 0);
    access(1'b0, 1'b1, 8'h41, 8'h88, 0);
    access(1'b1, 1'b0, 8'h40, 8'h00, 1);
    access(1'b1, 1'b0, 8'h41, 8'h00, 0);

    // held load request: one access per IDLE->ACCESS->DONE round
    access(1'b0, 1'b1, 8'h05, 8'h55, 0);
    access(1'b1, 1'b0, 8'h05, 8'h00, 2);
    prev = done_cyc;
    access(1'b1, 1'b0, 8'h05, 8'h00, 2);
    check("held_gap_a", done_cyc - prev, 7);
    prev = done_cyc;
    access(1'b1, 1'b0, 8'h05, 8'h00, 0);
    check("held_gap_b", done_cyc - prev, 7);

    // latency 1 corner
    sel1 = 1'b1;
    access(1'b0, 1'b1, 8'h90, 8'h3C, 0);
    access(1'b1, 1'b0, 8'h90, 8'h00, 0);
    access(1'b1, 1'b1, 8'hFF, 8'hE1, 0);
    access(1'b1, 1'b0, 8'hFF, 8'h00, 2);
    prev = done_cyc;
    access(1'b1, 1'b0, 8'hFF, 8'h00, 0);
    check("lat1_held_gap", done_cyc - prev, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Multi-cycle 256x8 data memory placed directly downstream of the ALU. The ALU result drives ADDRESS; the register-file output drives WRITEDATA.
- Serves load/store requests issued by the control unit.
- Stalls the single-cycle core through BUSYWAIT until each access completes.
- Returns load data on READDATA for the register-file write-back mux.

Parameters:
- ADDR_WIDTH, 8, address bus width.
- DATA_WIDTH, 8, data word width.
- DEPTH, 256, number of words; must equal 2**ADDR_WIDTH.
- ACCESS_LATENCY, 5, clock edges from request acceptance to completion; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- READ  input  1  load request; level, held by the core while stalled.
- WRITE  input  1  store request; level, held by the core while stalled.
- ADDRESS  input  ADDR_WIDTH  word address (ALU RESULT).
- WRITEDATA  input  DATA_WIDTH  store data.
- READDATA  output  DATA_WIDTH  load data, registered.
- BUSYWAIT  output  1  stall request to the core.

Behaviour:
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- Reset (RESET==0 at a rising edge):
  - state<=IDLE, latency counter<=0, READDATA<=0, internal latched request cleared.
  - Memory array contents are not cleared.
  - Reset during ACCESS aborts the access: no array write happens and READDATA is not updated.
- BUSYWAIT is combinational: 1 when (state==IDLE and (READ or WRITE)) or state==ACCESS; 0 in DONE and in idle-with-no-request. BUSYWAIT is therefore 0 during reset only if no request is present.
- IDLE: at an edge with READ or WRITE high:
  - Latch ADDRESS, WRITEDATA and the request type.
  - Load the counter with ACCESS_LATENCY-1 and go to ACCESS.
  - If READ and WRITE are both high, WRITE wins (store performed, READDATA unchanged).
- ACCESS:
  - The counter decrements each edge.
  - At the edge where the counter==0: a store writes the latched data to mem[latched address]; a load sets READDATA<=mem[latched address]. Then go to DONE.
  - ADDRESS/WRITEDATA/READ/WRITE changes during ACCESS are ignored.
  - Dropping READ/WRITE mid-access does not cancel it.
- Timing:
  - Request accepted at edge T0; completion at edge T0+ACCESS_LATENCY.
  - BUSYWAIT is high from request assertion until completion.
- DONE:
  - Lasts exactly one cycle with BUSYWAIT=0, so the core advances its PC at the next edge.
  - A request present during DONE is not accepted; the next edge always returns to IDLE.
  - The following instruction's request is therefore accepted no earlier than the edge after IDLE is re-entered.
- READDATA holds its last loaded value across stores, idle cycles and DONE. It changes only on load completion or reset.
- Addresses wrap naturally at ADDR_WIDTH bits. With DEPTH==2**ADDR_WIDTH, no out-of-range condition exists.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined:
  - Adds outputs LOAD_COUNT[15:0] and STORE_COUNT[15:0].
  - Each increments by 1 at the completion edge of a load or store respectively; an aborted access does not count.
  - Both saturate at 16'hFFFF and are cleared to 0 by reset.
  - A READ+WRITE collision counts as a store only.
- When not defined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Store then load:
  - Stimulus: LAT=5, RESET released; WRITE=1, ADDRESS=8'h10, WRITEDATA=8'h5A accepted at edge T0.
  - Response: BUSYWAIT=1 until T0+5, then 0 for one cycle.
  - Follow-up: READ at 8'h10 gives READDATA=8'h5A after completion; STORE_COUNT=1 and LOAD_COUNT=1 when DMEM_STATS_EN is defined.
- Reset mid-store:
  - Preload mem[8'h20]=8'h11. Issue WRITE 8'hFF to 8'h20 and hold RESET=0 at T0+2.
  - Response: state returns to IDLE, READDATA=0. A later load of 8'h20 returns 8'h11.
- Read/write collision:
  - Stimulus: READ=1 and WRITE=1, ADDRESS=8'h03, WRITEDATA=8'hC3.
  - Response: mem[3]=8'hC3 and READDATA keeps its prior value.
- Input change during ACCESS:
  - Stimulus: request load at 8'h40 (mem=8'h77), then switch ADDRESS to 8'h41 at T0+1.
  - Response: READDATA=8'h77.
- Held request across DONE:
  - Stimulus: keep READ=1 at 8'h05 continuously.
  - Response: exactly one access per IDLE->ACCESS->DONE cycle, with the next acceptance at T0+LAT+2.
- Latency corner, LAT=1:
  - Response: completion at T0+1 and a single-cycle BUSYWAIT high.
  - With DMEM_STATS_EN defined: 65536 stores leave STORE_COUNT=16'hFFFF.
